// File: rtl/w_update_bank_pkg.sv
// w_update_pkg: shared FSM state type and arithmetic constants for the weight-update bank
package w_update_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic longint round_const(int qp);
        return longint'(1) << (qp - 1);
    endfunction
    function automatic longint sat_max(int width);
        return (longint'(1) << (width - 1)) - 1;
    endfunction
    function automatic longint sat_min(int width);
        return -(longint'(1) << (width - 1));
    endfunction
endpackage

// File: rtl/w_update_bank_if.sv
// w_update_bank_if: control, tap-input and weight-bank bundle of the weight-update engine
interface w_update_bank_if #(parameter int WIDTH = 16, parameter int TAPS = 8);
    logic                    start;
    logic                    clear;
    logic [WIDTH-1:0]        mu_error;
    logic [TAPS*WIDTH-1:0]   x_vec;
    logic                    busy;
    logic                    done;
    logic [TAPS*WIDTH-1:0]   weights;
    modport master(output start, clear, mu_error, x_vec, input busy, done, weights);
    modport slave(input start, clear, mu_error, x_vec, output busy, done, weights);
endinterface

// File: rtl/w_update_bank_mac.sv
// w_update_mac: rounded Q-format product for one tap and weight add (saturating under W_UPDATE_BANK_SAT_EN)
module w_update_mac
    import w_update_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] mu,
    input  logic signed [WIDTH-1:0] w,
    input  logic signed [WIDTH-1:0] p_in,
    output logic signed [WIDTH-1:0] p,
    output logic signed [WIDTH-1:0] sum
);
    logic signed [2*WIDTH-1:0] full;
    assign full = x * mu + (2*WIDTH)'(round_const(QP));
    assign p = WIDTH'(full >>> QP);
`ifdef W_UPDATE_BANK_SAT_EN
    logic [WIDTH:0] s;
    assign s = {w[WIDTH-1], w} + {p_in[WIDTH-1], p_in};
    assign sum = s[WIDTH] != s[WIDTH-1] ? (s[WIDTH] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH)))
                                        : s[WIDTH-1:0];
`else
    assign sum = w + p_in;
`endif
endmodule

// File: rtl/w_update_bank.sv
// w_update_bank: multi-tap LMS weight bank updated through one pipelined shared multiplier.
// Define W_UPDATE_BANK_SAT_EN for saturating weight adds (default wraps).
module w_update_bank
    import w_update_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAPS  = 8
) (
    input  logic            clk,
    input  logic            reset,
    w_update_bank_if.slave  bus
);
    localparam int IW = $clog2(TAPS);
    state_t state, state_d;
    logic [IW-1:0] idx, wb_idx;
    logic last, wb_en;
    logic signed [WIDTH-1:0] mu_q, prod_q, prod_d, sum;
    logic signed [WIDTH-1:0] x_q [TAPS];
    logic signed [WIDTH-1:0] w [TAPS];
    assign last   = idx == IW'(TAPS - 1);
    // the product registered last cycle belongs to tap idx-1; DRAIN holds idx at the final tap
    assign wb_en  = (state == RUN && idx != '0) || state == DRAIN;
    assign wb_idx = state == DRAIN ? idx : idx - IW'(1);
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    w_update_mac #(.WIDTH(WIDTH), .QP(QP)) mac (
        .x(x_q[idx]), .mu(mu_q), .w(w[wb_idx]), .p_in(prod_q), .p(prod_d), .sum(sum)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_d;
    always_comb begin
        state_d = bus.clear       ? IDLE
                : state == IDLE   ? (bus.start ? RUN : IDLE)
                : state == RUN    ? (last ? DRAIN : RUN)
                : state == DRAIN  ? DONE
                :                   IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx    <= '0;
            mu_q   <= '0;
            prod_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                w[i]   <= '0;
            end
        end else if (bus.clear) begin
            idx    <= '0;
            prod_q <= '0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                idx  <= '0;
                mu_q <= bus.mu_error;
                for (int i = 0; i < TAPS; i++) x_q[i] <= bus.x_vec[i*WIDTH +: WIDTH];
            end
            if (state == RUN) begin
                prod_q <= prod_d;
                if (!last) idx <= idx + IW'(1);
            end
            if (wb_en) w[wb_idx] <= sum;
        end
    end
    for (genvar k = 0; k < TAPS; k++) begin : g_out
        assign bus.weights[k*WIDTH +: WIDTH] = w[k];
    end
endmodule

// File: tb/tb_w_update_bank.sv
// tb_w_update_bank: randomized scoreboard bench for w_update_bank (WIDTH=16, QP=12, TAPS=4)
module tb_w_update_bank;
    localparam int WIDTH = 16;
    localparam int QP    = 12;
    localparam int TAPS  = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    w_update_bank_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus();
    w_update_bank #(.WIDTH(WIDTH), .QP(QP), .TAPS(TAPS)) dut (.clk(clk), .reset(reset), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q [$];
    int model_w [TAPS];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int wrap_w(input longint v);
        logic signed [WIDTH-1:0] t;
        t = v[WIDTH-1:0];
        return int'(t);
    endfunction
    function automatic int s16(input logic [WIDTH-1:0] v);
        return int'($signed(v));
    endfunction
    // weight += round(x*mu / 2^QP), wrapped to WIDTH bits or clamped when saturating
    function automatic int upd(input int wv, input int x, input int mu);
        longint s;
        s = longint'(wv) + wrap_w((longint'(x) * longint'(mu) + (longint'(1) << (QP - 1))) >>> QP);
`ifdef W_UPDATE_BANK_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return wrap_w(s);
    endfunction
    function automatic logic [63:0] pack_model();
        logic [63:0] r;
        for (int k = 0; k < TAPS; k++) r[k*WIDTH +: WIDTH] = WIDTH'(model_w[k]);
        return r;
    endfunction
    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction
    always @(negedge clk)
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_done: got done=1 expected no pass pending at %0t", $time);
            end else check("pass_weights", bus.weights, exp_q.pop_front());
        end
    task automatic start_pass(input logic [63:0] x, input logic [15:0] mu, input bit completes);
        @(negedge clk);
        bus.x_vec = x;
        bus.mu_error = mu;
        bus.start = 1'b1;
        if (completes) begin
            for (int k = 0; k < TAPS; k++) model_w[k] = upd(model_w[k], s16(x[k*WIDTH +: WIDTH]), s16(mu));
            exp_q.push_back(pack_model());
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x_vec = rand64();
        bus.mu_error = WIDTH'($urandom);
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask
    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        for (int k = 0; k < TAPS; k++) model_w[k] = 0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.mu_error = '0;
        bus.x_vec = '0;
        for (int k = 0; k < TAPS; k++) model_w[k] = 0;
        repeat (2) cyc();
        check("reset_weights", bus.weights, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;
        start_pass({4{16'h1000}}, 16'h0800, 1'b1);
        check("busy_e0", bus.busy, 1);
        cyc();
        check("w0_e1", bus.weights[15:0], 0);
        cyc();
        check("w0_e2", bus.weights[15:0], 16'h0800);
        cyc();
        cyc();
        check("w3_e4", bus.weights[63:48], 0);
        check("done_e4", bus.done, 0);
        cyc();
        check("w3_e5", bus.weights[63:48], 16'h0800);
        check("done_e5", bus.done, 1);
        cyc();
        check("busy_e6", bus.busy, 0);
        check("done_e6", bus.done, 0);
        check("basic_all", bus.weights, {4{16'h0800}});
        do_clear();
        check("clear_zero", bus.weights, 0);
        start_pass({16'h2000, 16'h0000, 16'hF000, 16'h0001}, 16'h0800, 1'b1);
        wait_idle();
        check("round_sign", bus.weights, {16'h1000, 16'h0000, 16'hF800, 16'h0001});
        do_clear();
        repeat (2) begin
            start_pass({48'h0, 16'h1000}, 16'h3F80, 1'b1);
            wait_idle();
        end
        check("preload", bus.weights, {48'h0, 16'h7F00});
        start_pass({48'h0, 16'h1000}, 16'h0800, 1'b1);
        wait_idle();
`ifdef W_UPDATE_BANK_SAT_EN
        check("overflow", bus.weights[15:0], 16'h7FFF);
`else
        check("overflow", bus.weights[15:0], 16'h8700);
`endif
        do_clear();
        start_pass(rand64(), WIDTH'($urandom), 1'b1);
        cyc();
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_vec = rand64();
        bus.mu_error = WIDTH'($urandom);
        cyc();
        bus.start = 1'b0;
        wait_idle();
        repeat (8) cyc();
        check("no_restart", bus.busy, 0);
        check("one_done", exp_q.size(), 0);
        start_pass(rand64(), WIDTH'($urandom), 1'b0);
        repeat (2) cyc();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        for (int k = 0; k < TAPS; k++) model_w[k] = 0;
        check("midclear_w", bus.weights, 0);
        check("midclear_busy", bus.busy, 0);
        repeat (6) cyc();
        check("midclear_idle", bus.busy, 0);
        start_pass({4{16'h1000}}, 16'h0800, 1'b1);
        wait_idle();
        @(negedge clk);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < TAPS; k++) model_w[k] = 0;
        check("clrstart_w", bus.weights, 0);
        check("clrstart_busy", bus.busy, 0);
        repeat (6) cyc();
        check("clrstart_idle", bus.busy, 0);
        start_pass(rand64(), WIDTH'($urandom_range(1, 65535)), 1'b1);
        wait_idle();
        start_pass(rand64(), WIDTH'($urandom), 1'b0);
        repeat (2) cyc();
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < TAPS; k++) model_w[k] = 0;
        check("areset_w", bus.weights, 0);
        check("areset_busy", bus.busy, 0);
        check("areset_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b1;
        start_pass({4{16'h1000}}, 16'h0800, 1'b1);
        wait_idle();
        check("after_reset", bus.weights, {4{16'h0800}});
        repeat (25) begin
            if ($urandom_range(0, 5) == 0) do_clear();
            start_pass(rand64(), WIDTH'($urandom), 1'b1);
            wait_idle();
        end
        repeat (4) cyc();
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
